// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer
//   Runs one single-byte I2C register transaction per command through the
//   I2C register-map block: load slave address, load register address, then
//   start+stop. It polls busy/nack and returns one response per command.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_rw, cmd_slave_addr,
//   cmd_reg_addr, cmd_wdata       command fields (1=read)
//   rsp_valid/rsp_ready           response handshake (held until ready)
//   rsp_rdata, rsp_nack,
//   rsp_timeout                   response fields
//   i2c_clk_div_lo/hi             SCL divider (constant CLK_DIV)
//   i2c_ctrl                      {0,ld_reg,ld_slave,rw,stop,start,mode,en}
//   i2c_tx                        byte to the I2C block
//   i2c_rx                        byte from the I2C block
//   i2c_status                    {5'b0,nack,done,busy}
//
// Build option
//   I2C_SEQ_RETRY_EN : retry a NACKed transaction up to MAX_RETRY times
//                      before reporting rsp_nack.

module i2c_txn_sequencer #(
  parameter logic [15:0] CLK_DIV     = 16'd250,
  parameter logic        MODE        = 1'b0,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_slave_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic [7:0] i2c_clk_div_lo,
  output logic [7:0] i2c_clk_div_hi,
  output logic [7:0] i2c_ctrl,
  output logic [7:0] i2c_tx,
  input  logic [7:0] i2c_rx,
  input  logic [7:0] i2c_status
);

  typedef enum logic [2:0] {S_IDLE, S_LD_SA, S_LD_RA, S_START, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic        rw_q;
  logic [6:0]  sa_q;
  logic [7:0]  ra_q;
  logic [7:0]  wd_q;
  logic [19:0] tcnt;

  logic busy, nack, timed_out;
  assign busy      = i2c_status[0];
  assign nack      = i2c_status[2];
  // This is the TIMEOUT_CYC-th cycle spent in START/WAIT.
  assign timed_out = (tcnt >= TIMEOUT_CYC - 20'd1);

  logic unused_status;
  assign unused_status = ^{i2c_status[7:3], i2c_status[1]};

`ifdef I2C_SEQ_RETRY_EN
  logic [7:0] retry_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = MAX_RETRY[0];
`endif

  assign i2c_clk_div_lo = CLK_DIV[7:0];
  assign i2c_clk_div_hi = CLK_DIV[15:8];

  // Control byte with en=1; mode always follows MODE while enabled.
  function automatic logic [7:0] ctl(input logic ld_reg, input logic ld_sa,
                                     input logic rw, input logic stop_start);
    return {1'b0, ld_reg, ld_sa, rw, stop_start, stop_start, MODE, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      i2c_ctrl    <= 8'h00;
      i2c_tx      <= 8'h00;
      rw_q        <= 1'b0;
      sa_q        <= 7'h00;
      ra_q        <= 8'h00;
      wd_q        <= 8'h00;
      tcnt        <= 20'd0;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          i2c_ctrl <= 8'h00;
          if (cmd_valid && cmd_ready) begin
            rw_q      <= cmd_rw;
            sa_q      <= cmd_slave_addr;
            ra_q      <= cmd_reg_addr;
            wd_q      <= cmd_wdata;
            cmd_ready <= 1'b0;
            i2c_tx    <= {1'b0, cmd_slave_addr};
            i2c_ctrl  <= ctl(1'b0, 1'b1, cmd_rw, 1'b0);
            // Cleared once per command so retries share one timeout budget.
            tcnt      <= 20'd0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt <= 8'd0;
`endif
            state     <= S_LD_SA;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_LD_SA: begin
          i2c_tx   <= ra_q;
          i2c_ctrl <= ctl(1'b1, 1'b0, rw_q, 1'b0);
          state    <= S_LD_RA;
        end
        S_LD_RA: begin
          i2c_tx   <= wd_q;
          i2c_ctrl <= ctl(1'b0, 1'b0, rw_q, 1'b1);
          state    <= S_START;
        end
        S_START, S_WAIT: begin
          tcnt <= tcnt + 20'd1;
          if (timed_out) begin
            // One cycle with en=0 aborts whatever the core is doing.
            i2c_ctrl    <= 8'h00;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_nack    <= 1'b0;
            rsp_rdata   <= 8'h00;
            state       <= S_RESP;
          end else if (state == S_START) begin
            if (busy) begin
              i2c_ctrl <= ctl(1'b0, 1'b0, rw_q, 1'b0);
              state    <= S_WAIT;
            end
          end else if (!busy) begin
            if (nack) begin
`ifdef I2C_SEQ_RETRY_EN
              if (retry_cnt < 8'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 8'd1;
                i2c_tx    <= {1'b0, sa_q};
                i2c_ctrl  <= ctl(1'b0, 1'b1, rw_q, 1'b0);
                state     <= S_LD_SA;
              end else begin
                i2c_ctrl  <= ctl(1'b0, 1'b0, 1'b0, 1'b0);
                rsp_valid <= 1'b1;
                rsp_nack  <= 1'b1;
                rsp_rdata <= 8'h00;
                state     <= S_RESP;
              end
`else
              i2c_ctrl  <= ctl(1'b0, 1'b0, 1'b0, 1'b0);
              rsp_valid <= 1'b1;
              rsp_nack  <= 1'b1;
              rsp_rdata <= 8'h00;
              state     <= S_RESP;
`endif
            end else begin
              i2c_ctrl  <= ctl(1'b0, 1'b0, 1'b0, 1'b0);
              rsp_valid <= 1'b1;
              rsp_nack  <= 1'b0;
              rsp_rdata <= rw_q ? i2c_rx : 8'h00;
              state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 8'h00;
            i2c_ctrl    <= 8'h00;
            cmd_ready   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            i2c_ctrl <= ctl(1'b0, 1'b0, 1'b0, 1'b0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: random register transactions against a small
// I2C core model, with a response scoreboard drained by an independent monitor.
module tb_i2c_txn_sequencer;
  localparam int TO   = 100;
  localparam int MAXR = 2;
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_slave_addr;
  logic [7:0] cmd_reg_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_nack, rsp_timeout;
  logic [7:0] rsp_rdata, i2c_clk_div_lo, i2c_clk_div_hi, i2c_ctrl, i2c_tx, i2c_rx, i2c_status;

  logic st_busy, st_done, st_nack;
  assign i2c_status = {5'b0, st_nack, st_done, st_busy};

  i2c_txn_sequencer #(.TIMEOUT_CYC(20'(TO)), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .i2c_clk_div_lo(i2c_clk_div_lo), .i2c_clk_div_hi(i2c_clk_div_hi),
    .i2c_ctrl(i2c_ctrl), .i2c_tx(i2c_tx), .i2c_rx(i2c_rx), .i2c_status(i2c_status)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       nack;
    logic       tmo;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model knobs and the command currently expected on the bus.
  logic       core_nack = 1'b0, core_mute = 1'b0;
  logic [7:0] core_rx = 8'h00;
  int         core_hold = 5;
  int         rdy_mode = 0;   // 0 random, 1 low, 2 high
  logic       exp_rw = 1'b0;
  logic [6:0] exp_sa = 7'h0;
  logic [7:0] exp_ra = 8'h0, exp_wd = 8'h0;
  int         phases = 0;

  // I2C core: after seeing start it goes busy (short random delay), stays
  // busy a few cycles, then reports done with the configured nack/rx.
  initial begin : core
    int dly, bcnt;
    st_busy = 1'b0; st_done = 1'b0; st_nack = 1'b0; i2c_rx = 8'h00;
    dly = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !i2c_ctrl[0]) begin
        st_busy = 1'b0;
        dly = $urandom_range(0, 3);
      end else if (st_busy) begin
        if (bcnt > 0) bcnt--;
        else begin
          st_busy = 1'b0; st_done = 1'b1; st_nack = core_nack; i2c_rx = core_rx;
          dly = $urandom_range(0, 3);
        end
      end else if (i2c_ctrl[2] && !core_mute) begin
        if (dly > 0) dly--;
        else begin
          st_busy = 1'b1; st_done = 1'b0; st_nack = 1'b0;
          bcnt = $urandom_range(1, core_hold);
        end
      end
    end
  end

  // Bus sequence checker: each load/start phase carries the expected bytes
  // and follows the previous phase directly.
  initial begin : seqchk
    logic [7:0] prev;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (i2c_ctrl[5])
          chk("ld_slave", {i2c_ctrl, i2c_tx}, {(exp_rw ? 8'h31 : 8'h21), 1'b0, exp_sa});
        if (i2c_ctrl[6]) begin
          chk("ld_reg", {i2c_ctrl, i2c_tx}, {(exp_rw ? 8'h51 : 8'h41), exp_ra});
          chk("ld_reg_order", {31'd0, prev[5]}, 32'd1);
        end
        if (i2c_ctrl[2]) begin
          chk("start", {i2c_ctrl, i2c_tx}, {(exp_rw ? 8'h1D : 8'h0D), exp_wd});
          if (!prev[2]) begin
            chk("start_order", {31'd0, prev[6]}, 32'd1);
            phases++;
          end
        end
      end
      prev = rst_n ? i2c_ctrl : 8'h00;
    end
  end

  // Consumer ready driver.
  initial begin : rdy
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'($urandom_range(0, 1));
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Response monitor: every handshake pops and checks one expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
          if (!e.nack) chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        end
      end
    end
  end

  task automatic set_exp(input logic rw, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd,
                         input logic nk, input logic [7:0] rx, input logic tmo);
    exp_t e;
    exp_rw = rw; exp_sa = sa; exp_ra = ra; exp_wd = wd;
    core_nack = nk; core_rx = rx;
    e.rdata = (rw && !nk && !tmo) ? rx : 8'h00;
    e.nack  = nk && !tmo;
    e.tmo   = tmo;
    sb.push_back(e);
    phases = 0;
  endtask

  task automatic send(input logic rw, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd);
    int g;
    g = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_slave_addr = sa; cmd_reg_addr = ra; cmd_wdata = wd;
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_slave_addr = 7'($urandom); cmd_reg_addr = 8'($urandom); cmd_wdata = 8'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin @(negedge clk); g++; end
    chk("rsp_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_cmd(input logic rw, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] wd,
                        input logic nk, input logic [7:0] rx);
    set_exp(rw, sa, ra, wd, nk, rx, 1'b0);
    send(rw, sa, ra, wd);
    drain();
    chk("start_phases", 32'(phases), (nk && RETRY) ? 32'(MAXR + 1) : 32'd1);
  endtask

  initial begin : stim
    int g, scyc;
    logic [7:0] held_rd;
    logic held_nk, held_to;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave_addr = 7'h0; cmd_reg_addr = 8'h0; cmd_wdata = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ctrl_tx", {16'd0, i2c_ctrl, i2c_tx}, 32'd0);
    chk("rst_rsp_fields", {22'd0, rsp_rdata, rsp_nack, rsp_timeout}, 32'd0);
    chk("clk_div", {16'd0, i2c_clk_div_hi, i2c_clk_div_lo}, 32'd250);
    rst_n = 1'b1;

    // Directed cases.
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 8'h77);
    do_cmd(1'b1, 7'h50, 8'h22, 8'h00, 1'b0, 8'h3C);
    do_cmd(1'b0, 7'h1A, 8'h05, 8'h5A, 1'b1, 8'h00);

    // Timeout: core never goes busy.
    core_mute = 1'b1; rdy_mode = 1;
    set_exp(1'b0, 7'h33, 8'h44, 8'h55, 1'b0, 8'h00, 1'b1);
    send(1'b0, 7'h33, 8'h44, 8'h55);
    scyc = 0; g = 0;
    while (!rsp_valid && g < 500) begin
      @(negedge clk);
      if (i2c_ctrl[2]) scyc++;
      g++;
    end
    chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_start_cycles", 32'(scyc), 32'(TO));
    chk("tmo_abort_ctrl", {24'd0, i2c_ctrl}, 32'd0);
    @(negedge clk);
    chk("tmo_resp_ctrl", {24'd0, i2c_ctrl}, 32'h01);
    core_mute = 1'b0; rdy_mode = 0;
    drain();

    // Response held back while another command waits.
    rdy_mode = 1;
    set_exp(1'b1, 7'h21, 8'h31, 8'h41, 1'b0, 8'hC3, 1'b0);
    send(1'b1, 7'h21, 8'h31, 8'h41);
    g = 0;
    while (!rsp_valid && g < 300) begin @(negedge clk); g++; end
    chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    held_rd = rsp_rdata; held_nk = rsp_nack; held_to = rsp_timeout;
    set_exp(1'b0, 7'h62, 8'h72, 8'h82, 1'b0, 8'h00, 1'b0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_slave_addr = 7'h62; cmd_reg_addr = 8'h72; cmd_wdata = 8'h82;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_rsp", {22'd0, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout},
          {22'd0, 1'b1, held_rd, held_nk, held_to});
    end
    rdy_mode = 2;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    chk("b2b_accept", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset while the core is busy in WAIT.
    core_hold = 30;
    set_exp(1'b0, 7'h0F, 8'hF0, 8'h99, 1'b0, 8'h00, 1'b0);
    send(1'b0, 7'h0F, 8'hF0, 8'h99);
    g = 0;
    while (!(st_busy && i2c_ctrl[0] && !i2c_ctrl[2]) && g < 100) begin @(negedge clk); g++; end
    chk("mid_wait_reached", {31'd0, st_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl_tx", {16'd0, i2c_ctrl, i2c_tx}, 32'd0);
    chk("mid_rst_hs", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    chk("mid_rst_rsp", {22'd0, rsp_rdata, rsp_nack, rsp_timeout}, 32'd0);
    sb.delete();
    core_hold = 5;
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(1'b1, 7'h48, 8'h0C, 8'h00, 1'b0, 8'h5E);

    // Random traffic.
    for (int i = 0; i < 25; i++)
      do_cmd(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0), 8'($urandom));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
